// File: rtl/onehot_pkg.sv
// Shared types and constants for the one-hot LED index sequencer.
package onehot_pkg;

  localparam int CODE_W = 3;

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'd0,
    MODE_UP     = 2'd1,
    MODE_DOWN   = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_e;

endpackage

// File: rtl/onehot_prescaler.sv
// Programmable tick prescaler: counts 0..T-1 with T = 2^(rate_sel + BASE_SHIFT).
module onehot_prescaler #(
  parameter int PRESCALE_W = 24,
  parameter int BASE_SHIFT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       clr_i,
  input  logic [2:0] rate_sel_i,
  output logic       req_o
);

  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] count_q;
  logic [PRESCALE_W-1:0] count_d;
  logic [PRESCALE_W-1:0] last_w;
  logic                  terminal_w;

  // At the largest legal shift the 1 falls off the top and T-1 wraps to all ones.
  assign last_w     = (ONE << (PRESCALE_W'(rate_sel_i) + PRESCALE_W'(BASE_SHIFT))) - ONE;
  assign terminal_w = (count_q == last_w);
  assign req_o      = en_i & ~clr_i & terminal_w;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = terminal_w ? '0 : count_q + ONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/onehot_step_seq.sv
// Sequencer producing the 3-bit index for the one-hot LED decoder; advances on prescaled ticks or manual steps.
module onehot_step_seq
  import onehot_pkg::*;
#(
  parameter int PRESCALE_W = 24,
  parameter int BASE_SHIFT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        pattern_sel,
  input  logic [2:0]        rate_sel,
  input  logic              step_req,
  output logic [CODE_W-1:0] code,
  output logic              tick,
  output logic              dir
);

  logic [CODE_W-1:0] code_q, code_d;
  logic              tick_q, tick_d;
  logic              dir_q, dir_d;
  logic              step_prev_q;
  logic [1:0]        pattern_q;
  logic [2:0]        rate_q;

  mode_e mode_w;
  logic  sel_change_w;
  logic  step_edge_w;
  logic  presc_req_w;
  logic  advance_w;

  assign mode_w       = mode_e'(pattern_sel);
  assign sel_change_w = (pattern_sel != pattern_q) || (rate_sel != rate_q);
  assign step_edge_w  = step_req & ~step_prev_q;
  assign advance_w    = en & (step_edge_w | presc_req_w);

  // HOLD parks the prescaler at zero, same as a selection change.
  onehot_prescaler #(
    .PRESCALE_W (PRESCALE_W),
    .BASE_SHIFT (BASE_SHIFT)
  ) u_prescaler (
    .clk        (clk),
    .rst        (rst),
    .en_i       (en),
    .clr_i      (sel_change_w | (mode_w == MODE_HOLD)),
    .rate_sel_i (rate_q),
    .req_o      (presc_req_w)
  );

  always_comb begin
    code_d = code_q;
    dir_d  = dir_q;
    tick_d = advance_w;
    if (advance_w) begin
      unique case (mode_w)
        MODE_HOLD, MODE_UP: code_d = code_q + 3'd1;
        MODE_DOWN:          code_d = code_q - 3'd1;
        MODE_BOUNCE: begin
          if (!dir_q) begin
            if (code_q == 3'd7) begin
              code_d = 3'd6;
              dir_d  = 1'b1;
            end else begin
              code_d = code_q + 3'd1;
            end
          end else begin
            if (code_q == 3'd0) begin
              code_d = 3'd1;
              dir_d  = 1'b0;
            end else begin
              code_d = code_q - 3'd1;
            end
          end
        end
        default: code_d = code_q;
      endcase
    end
    if (mode_w != MODE_BOUNCE) begin
      dir_d = 1'b0;
    end
  end

  // Step history and selection copies track inputs even while disabled, so re-enabling sees no stale events.
  always_ff @(posedge clk) begin
    if (rst) begin
      code_q      <= '0;
      tick_q      <= 1'b0;
      dir_q       <= 1'b0;
      step_prev_q <= 1'b0;
      pattern_q   <= pattern_sel;
      rate_q      <= rate_sel;
    end else begin
      code_q      <= code_d;
      tick_q      <= tick_d;
      dir_q       <= dir_d;
      step_prev_q <= step_req;
      pattern_q   <= pattern_sel;
      rate_q      <= rate_sel;
    end
  end

  assign code = code_q;
  assign tick = tick_q;
  assign dir  = dir_q;

endmodule

// File: tb/tb_onehot_step_seq.sv
// Randomized and directed bench for onehot_step_seq against a behavioural model (PRESCALE_W=8, BASE_SHIFT=1).
module tb_onehot_step_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic [1:0] pattern_sel = 2'd1;
  logic [2:0] rate_sel = 3'd0;
  logic       step_req = 1'b0;
  logic [2:0] code;
  logic       tick;
  logic       dir;

  int checks = 0;
  int failures = 0;

  // Behavioural model state.
  logic [2:0] m_code;
  logic       m_dir;
  logic       m_tick;
  int         m_n;
  logic       m_prev;
  logic [1:0] m_pq;
  logic [2:0] m_rq;

  onehot_step_seq #(.PRESCALE_W(8), .BASE_SHIFT(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .pattern_sel (pattern_sel),
    .rate_sel    (rate_sel),
    .step_req    (step_req),
    .code        (code),
    .tick        (tick),
    .dir         (dir)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  // Model: ticks fire every T enabled cycles since the last restart; BOUNCE walks a 14-position triangle.
  task automatic model_edge();
    int  t;
    int  p;
    bit  fire;
    bit  adv;
    bit  edge_s;
    if (rst) begin
      m_code = 3'd0; m_dir = 1'b0; m_tick = 1'b0; m_n = 0;
      m_prev = 1'b0; m_pq = pattern_sel; m_rq = rate_sel;
      return;
    end
    t      = 2 << rate_sel;
    edge_s = step_req && !m_prev;
    fire   = 1'b0;
    if (pattern_sel != m_pq || rate_sel != m_rq || pattern_sel == 2'd0) begin
      m_n = 0;
    end else if (en) begin
      m_n  = m_n + 1;
      fire = (m_n % t) == 0;
    end
    adv    = en && (edge_s || fire);
    m_tick = adv;
    if (adv) begin
      case (pattern_sel)
        2'd0, 2'd1: m_code = 3'((int'(m_code) + 1) % 8);
        2'd2:       m_code = 3'((int'(m_code) + 7) % 8);
        default: begin
          p      = m_dir ? ((14 - int'(m_code)) % 14) : int'(m_code);
          p      = (p + 1) % 14;
          m_code = 3'((p <= 7) ? p : 14 - p);
          m_dir  = (p >= 8) || (p == 0);
        end
      endcase
    end
    if (pattern_sel != 2'd3) m_dir = 1'b0;
    m_prev = step_req;
    m_pq   = pattern_sel;
    m_rq   = rate_sel;
  endtask

  // Advance one clock; outputs are stable 1 time unit after the edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset(input logic [1:0] pat, input logic [2:0] rate);
    rst = 1'b1; en = 1'b1; step_req = 1'b0;
    pattern_sel = pat; rate_sel = rate;
    repeat (2) cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; step_req = 1'b0; pattern_sel = 2'd1; rate_sel = 3'd0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if ({code, tick, dir} !== 5'b0) begin
        failures++;
        $display("FAIL reset_hold cycle=%0d code=%0d tick=%0b dir=%0b expected 0/0/0", i, code, tick, dir);
      end
    end
    rst = 1'b0;
    cycle();
    checks++;
    if (tick !== 1'b0 || code !== 3'd0) begin
      failures++;
      $display("FAIL reset_release_c1 code=%0d tick=%0b expected code=0 tick=0", code, tick);
    end
    cycle();
    checks++;
    if (tick !== 1'b1 || code !== 3'd1) begin
      failures++;
      $display("FAIL reset_first_tick code=%0d tick=%0b expected code=1 tick=1", code, tick);
    end
  endtask

  task automatic test_up_wrap();
    int  ticks = 0;
    bit  wrapped = 0;
    logic [2:0] last = 3'd0;
    do_reset(2'd1, 3'd0);
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (tick) begin
        ticks++;
        checks++;
        if (code !== 3'(ticks % 8)) begin
          failures++;
          $display("FAIL up_code tick#%0d code=%0d expected %0d", ticks, code, ticks % 8);
        end
        if (last == 3'd7 && code == 3'd0) wrapped = 1;
        last = code;
      end
    end
    checks++;
    if (ticks != 10) begin
      failures++;
      $display("FAIL up_tick_count got=%0d expected 10", ticks);
    end
    checks++;
    if (!wrapped) begin
      failures++;
      $display("FAIL up_wrap 7->0 not observed got=0 expected 1");
    end
  endtask

  task automatic test_bounce();
    int exp_seq[15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    int exp_dir[15] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
    int k = 0;
    do_reset(2'd3, 3'd1);
    for (int i = 0; i < 64 && k < 15; i++) begin
      cycle();
      if (tick) begin
        checks++;
        if (code !== 3'(exp_seq[k]) || dir !== 1'(exp_dir[k])) begin
          failures++;
          $display("FAIL bounce_step%0d code=%0d dir=%0b expected code=%0d dir=%0d", k, code, dir, exp_seq[k], exp_dir[k]);
        end
        k++;
      end
    end
    checks++;
    if (k != 15) begin
      failures++;
      $display("FAIL bounce_steps got=%0d expected 15", k);
    end
  endtask

  task automatic test_down_switch();
    int n = 0;
    do_reset(2'd2, 3'd2);
    repeat (8) cycle();
    checks++;
    if (code !== 3'd7 || tick !== 1'b1) begin
      failures++;
      $display("FAIL down_first code=%0d tick=%0b expected code=7 tick=1", code, tick);
    end
    repeat (8) cycle();
    checks++;
    if (code !== 3'd6) begin
      failures++;
      $display("FAIL down_second code=%0d expected 6", code);
    end
    repeat (3) cycle();
    pattern_sel = 2'd1;
    cycle();
    while (n < 40 && !tick) begin
      cycle();
      n++;
    end
    checks++;
    if (n != 8 || code !== 3'd7) begin
      failures++;
      $display("FAIL switch_restart cycles=%0d code=%0d expected cycles=8 code=7", n, code);
    end
  endtask

  task automatic test_step();
    int ticks = 0;
    do_reset(2'd0, 3'd0);
    step_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (tick) ticks++;
    end
    step_req = 1'b0;
    checks++;
    if (ticks != 1 || code !== 3'd1) begin
      failures++;
      $display("FAIL hold_step ticks=%0d code=%0d expected ticks=1 code=1", ticks, code);
    end
    do_reset(2'd1, 3'd1);
    repeat (3) cycle();
    step_req = 1'b1;
    cycle();
    checks++;
    if (code !== 3'd1 || tick !== 1'b1) begin
      failures++;
      $display("FAIL step_coincident code=%0d tick=%0b expected code=1 tick=1", code, tick);
    end
    cycle();
    checks++;
    if (code !== 3'd1 || tick !== 1'b0) begin
      failures++;
      $display("FAIL step_coincident_after code=%0d tick=%0b expected code=1 tick=0", code, tick);
    end
    step_req = 1'b0;
  endtask

  task automatic test_enable();
    do_reset(2'd1, 3'd2);
    repeat (5) cycle();
    en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step_req = (i % 2) == 0;
      cycle();
      checks++;
      if (code !== 3'd0 || tick !== 1'b0) begin
        failures++;
        $display("FAIL enable_freeze cycle=%0d code=%0d tick=%0b expected code=0 tick=0", i, code, tick);
      end
    end
    en = 1'b1;
    repeat (2) cycle();
    checks++;
    if (code !== 3'd0 || tick !== 1'b0) begin
      failures++;
      $display("FAIL enable_no_stale code=%0d tick=%0b expected code=0 tick=0", code, tick);
    end
    cycle();
    checks++;
    if (code !== 3'd1 || tick !== 1'b1) begin
      failures++;
      $display("FAIL enable_resume code=%0d tick=%0b expected code=1 tick=1", code, tick);
    end
    step_req = 1'b0;
  endtask

  task automatic test_random();
    int errs = 0;
    do_reset(2'($urandom_range(0, 3)), 3'($urandom_range(0, 2)));
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      en  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) step_req = ~step_req;
      if ($urandom_range(0, 59) == 0) pattern_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) rate_sel = 3'($urandom_range(0, 2));
      cycle();
      checks++;
      if ({code, tick, dir} !== {m_code, m_tick, m_dir}) begin
        failures++;
        errs++;
        if (errs <= 10)
          $display("FAIL random_model cycle=%0d code=%0d tick=%0b dir=%0b expected code=%0d tick=%0b dir=%0b",
                   i, code, tick, dir, m_code, m_tick, m_dir);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_up_wrap();
    test_bounce();
    test_down_switch();
    test_step();
    test_enable();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
